reg_bank_reader: RTL and testbench
==================================

// Module: reg_bank_reader
// PURPOSE
//  Read-side responder for the bank of 16-bit write-enabled registers: serves
//  single or burst read requests over a valid/ready handshake and returns one
//  16-bit word per beat. Sits between the control/debug master and the flattened
//  Q outputs of the register bank. It never writes the bank.
// PARAMETERS
//  NREGS  8   number of 16-bit registers in the bank (power of 2, 2..16)
//  AW     3   address width, AW = log2(NREGS)
//  DW     16  data width per register
// PORTS
//  CLK        in   1         clock, rising edge
//  RST        in   1         reset, asynchronous, active-high
//  REQ_VALID  in   1         read request valid
//  REQ_READY  out  1         responder idle, request can be accepted
//  REQ_ADDR   in   AW        start register index
//  REQ_LEN    in   AW+1      number of beats, legal 1..NREGS
//  REG_Q      in   NREGS*DW  bank contents; reg i = REG_Q[i*DW +: DW]
//  RD_VALID   out  1         read beat valid
//  RD_READY   in   1         master accepts beat
//  RD_DATA    out  DW        beat data
//  RD_ADDR    out  AW        register index of current beat
//  RD_LAST    out  1         final beat of burst
//  BUSY       out  1         burst in progress
//  ERR        out  1         one-cycle pulse: illegal request rejected
// BEHAVIOUR
//  - Reset (async): state IDLE; REQ_READY=0, RD_VALID=0, RD_DATA=0,
//    RD_ADDR=0, RD_LAST=0, BUSY=0, ERR=0. All outputs are registered.
//  - REQ_READY rises on the first CLK edge after RST is released. It is high
//    only in IDLE, excluding the cycle right after an accept.
//  - FSM states: IDLE, SEND.
//  - IDLE, REQ_VALID&&REQ_READY (accept):
//    * If REQ_LEN==0 or REQ_LEN>NREGS: ERR=1 for one cycle, REQ_READY stays 1,
//      state stays IDLE, no beat is issued.
//    * Otherwise: state goes to SEND; REQ_READY=0; BUSY=1; RD_VALID=1;
//      RD_ADDR=REQ_ADDR; RD_DATA=REG_Q[REQ_ADDR]; RD_LAST=(REQ_LEN==1).
//      Remaining count = REQ_LEN-1. Latency is 1 cycle from accept to the
//      first RD_VALID.
//  - SEND, RD_VALID && !RD_READY: RD_DATA, RD_ADDR and RD_LAST hold stable.
//    Later changes on REG_Q are ignored until the beat completes.
//  - SEND, RD_VALID && RD_READY, not last: the next edge loads
//    RD_ADDR=(RD_ADDR+1) mod NREGS, RD_DATA=REG_Q[new addr], decrements the
//    count, and sets RD_LAST when count reaches 0. RD_VALID stays 1, giving
//    back-to-back beats with no bubble.
//  - SEND, RD_VALID && RD_READY, last: the next edge sets RD_VALID=0,
//    RD_LAST=0, BUSY=0, REQ_READY=1, state IDLE. RD_DATA and RD_ADDR hold
//    their last values.
//  - Address wrap: index NREGS-1 is followed by index 0, with no error.
//  - REQ_VALID during SEND is ignored; REQ_READY=0 there, so no accept occurs.
//  - REG_Q is sampled exactly at the edge that loads a beat (snapshot per beat).
//  - RST mid-burst: the burst is aborted immediately, all outputs return to
//    reset values, and no residual beat appears after release.
// TESTING
//  T1 Reset: RST=1 mid-burst -> same cycle RD_VALID=0, BUSY=0, REQ_READY=0;
//     REQ_READY=1 one edge after release.
//  T2 Single read: REG_Q[3]=16'hBEEF, REQ_ADDR=3, REQ_LEN=1, RD_READY=1 ->
//     next cycle RD_VALID=1, RD_DATA=BEEF, RD_ADDR=3, RD_LAST=1;
//     idle with REQ_READY=1 the cycle after.
//  T3 Burst with wrap: regs i=16'h1000+i, ADDR=6, LEN=4 -> beats 1006,1007,
//     1000,1001 on consecutive cycles, RD_LAST only on 1001.
//  T4 Backpressure: LEN=2, RD_READY=0 for 3 cycles on beat 0 while REG_Q[addr]
//     changes -> RD_DATA holds the original value; beat 1 follows one cycle
//     after RD_READY=1.
//  T5 Illegal: REQ_LEN=0, then REQ_LEN=9 -> one ERR pulse each, RD_VALID never
//     asserts, REQ_READY stays 1.
//  T6 Request during burst: REQ_VALID held high through a LEN=8 burst ->
//     exactly 8 beats, then a second request is accepted on the first
//     REQ_READY=1 cycle.

Source files
------------

// File: rtl/reg_bank_reader_if.sv
// rtl/reg_bank_reader_if.sv - request and read-beat channels of the register bank reader
//
// Purpose: bundles the request handshake, the read-beat handshake and the
//          status flags between the control/debug master and reg_bank_reader.
// Signals:
//   REQ_VALID/REQ_READY/REQ_ADDR/REQ_LEN  read request channel
//   RD_VALID/RD_READY/RD_DATA/RD_ADDR/RD_LAST  read beat channel
//   BUSY  burst in progress, ERR  one-cycle illegal-request pulse
// Modports: master (control/debug side), slave (reg_bank_reader side).

interface reg_bank_reader_if #(
   parameter int NREGS = 8,
   parameter int AW    = 3,
   parameter int DW    = 16
);
   logic          REQ_VALID;
   logic          REQ_READY;
   logic [AW-1:0] REQ_ADDR;
   logic [AW:0]   REQ_LEN;
   logic          RD_VALID;
   logic          RD_READY;
   logic [DW-1:0] RD_DATA;
   logic [AW-1:0] RD_ADDR;
   logic          RD_LAST;
   logic          BUSY;
   logic          ERR;

   modport master (
      output REQ_VALID, REQ_ADDR, REQ_LEN, RD_READY,
      input  REQ_READY, RD_VALID, RD_DATA, RD_ADDR, RD_LAST, BUSY, ERR
   );

   modport slave (
      input  REQ_VALID, REQ_ADDR, REQ_LEN, RD_READY,
      output REQ_READY, RD_VALID, RD_DATA, RD_ADDR, RD_LAST, BUSY, ERR
   );
endinterface

// File: rtl/reg_bank_reader.sv
// rtl/reg_bank_reader.sv - single/burst read responder for a 16-bit register bank
//
// Purpose: accepts a read request (start index, beat count) and returns one
//          register word per beat over a valid/ready handshake, wrapping the
//          index modulo NREGS. Illegal lengths (0 or > NREGS) are rejected
//          with a one-cycle ERR pulse. Never writes the bank.
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   REG_Q  flattened bank contents, reg i = REG_Q[i*DW +: DW]
//   bus    reg_bank_reader_if.slave: request channel, read-beat channel,
//          BUSY and ERR. All outputs are registered.

module reg_bank_reader #(
   parameter int NREGS = 8,
   parameter int AW    = 3,
   parameter int DW    = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREGS*DW-1:0] REG_Q,
   reg_bank_reader_if.slave    bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(NREGS);

   state_t        state_q,     state_d;
   logic          req_ready_q, req_ready_d;
   logic          rd_valid_q,  rd_valid_d;
   logic [DW-1:0] rd_data_q,   rd_data_d;
   logic [AW-1:0] rd_addr_q,   rd_addr_d;
   logic          rd_last_q,   rd_last_d;
   logic          busy_q,      busy_d;
   logic          err_q,       err_d;
   // Beats still to be loaded after the one currently presented.
   logic [AW:0]   cnt_q,       cnt_d;

   logic [DW-1:0] regs [NREGS];
   logic [AW-1:0] next_addr;
   logic          req_fire;
   logic          len_bad;

   for (genvar i = 0; i < NREGS; i++) begin : g_regs
      assign regs[i] = REG_Q[i*DW +: DW];
   end

   // NREGS is a power of two, so the AW-bit increment wraps NREGS-1 to 0.
   assign next_addr = rd_addr_q + AW'(1);
   assign req_fire  = bus.REQ_VALID && req_ready_q;
   assign len_bad   = (bus.REQ_LEN == '0) || (bus.REQ_LEN > LEN_MAX);

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rd_valid_d  = rd_valid_q;
      rd_data_d   = rd_data_q;
      rd_addr_d   = rd_addr_q;
      rd_last_d   = rd_last_q;
      busy_d      = busy_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            // Also raises REQ_READY on the first edge after reset release.
            req_ready_d = 1'b1;
            if (req_fire) begin
               if (len_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = SEND;
                  req_ready_d = 1'b0;
                  busy_d      = 1'b1;
                  rd_valid_d  = 1'b1;
                  rd_addr_d   = bus.REQ_ADDR;
                  rd_data_d   = regs[bus.REQ_ADDR];
                  rd_last_d   = (bus.REQ_LEN == (AW+1)'(1));
                  cnt_d       = bus.REQ_LEN - (AW+1)'(1);
               end
            end
         end

         SEND: begin
            req_ready_d = 1'b0;
            // RD_VALID is always high in SEND; without RD_READY everything
            // holds, so later REG_Q changes do not disturb the presented beat.
            if (bus.RD_READY) begin
               if (rd_last_q) begin
                  state_d     = IDLE;
                  req_ready_d = 1'b1;
                  rd_valid_d  = 1'b0;
                  rd_last_d   = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  rd_addr_d = next_addr;
                  rd_data_d = regs[next_addr];
                  cnt_d     = cnt_q - (AW+1)'(1);
                  rd_last_d = (cnt_q == (AW+1)'(1));
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_addr_q   <= '0;
         rd_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_addr_q   <= rd_addr_d;
         rd_last_q   <= rd_last_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.REQ_READY = req_ready_q;
   assign bus.RD_VALID  = rd_valid_q;
   assign bus.RD_DATA   = rd_data_q;
   assign bus.RD_ADDR   = rd_addr_q;
   assign bus.RD_LAST   = rd_last_q;
   assign bus.BUSY      = busy_q;
   assign bus.ERR       = err_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// tb/tb_reg_bank_reader.sv - scoreboard bench for reg_bank_reader

module tb_reg_bank_reader;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  a;
      logic        l;
   } beat_t;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [127:0] reg_q;
   logic [15:0]  regs_m [8];

   beat_t exp_q [$];
   int    n_assert = 0;
   int    n_fail   = 0;

   reg_bank_reader_if #(.NREGS(8), .AW(3), .DW(16)) bus ();

   reg_bank_reader #(.NREGS(8), .AW(3), .DW(16)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REG_Q (reg_q),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_regs();
      for (int i = 0; i < 8; i++) reg_q[i*16 +: 16] = regs_m[i];
   endtask

   task automatic push_burst(input int a, input int len);
      for (int k = 0; k < len; k++) begin
         beat_t b;
         b.a = 3'((a + k) % 8);
         b.d = regs_m[(a + k) % 8];
         b.l = (k == len - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Presents one request for exactly one accept edge.
   task automatic issue(input logic [2:0] a, input logic [3:0] l);
      int n = 0;
      while (!bus.REQ_READY && n < 50) begin
         tick();
         n++;
      end
      if (!bus.REQ_READY) check("req_ready_timeout", 32'(bus.REQ_READY), 32'd1);
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR  = a;
      bus.REQ_LEN   = l;
      tick();
      bus.REQ_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.BUSY && n < 100) begin
         tick();
         n++;
      end
      if (bus.BUSY) check("busy_timeout", 32'(bus.BUSY), 32'd0);
   endtask

   // Monitor: every completed beat is compared against the scoreboard head.
   always @(negedge CLK) begin
      if (!RST && bus.RD_VALID && bus.RD_READY) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(bus.RD_ADDR), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", 32'(bus.RD_DATA), 32'(e.d));
            check("beat_addr", 32'(bus.RD_ADDR), 32'(e.a));
            check("beat_last", 32'(bus.RD_LAST), 32'(e.l));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      logic [15:0] orig;

      bus.REQ_VALID = 1'b0;
      bus.REQ_ADDR  = '0;
      bus.REQ_LEN   = '0;
      bus.RD_READY  = 1'b0;
      for (int i = 0; i < 8; i++) regs_m[i] = 16'(i);
      apply_regs();

      // Reset state
      #2;
      check("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
      check("rst_rd_valid",  32'(bus.RD_VALID),  32'd0);
      check("rst_rd_data",   32'(bus.RD_DATA),   32'd0);
      check("rst_rd_addr",   32'(bus.RD_ADDR),   32'd0);
      check("rst_rd_last",   32'(bus.RD_LAST),   32'd0);
      check("rst_busy",      32'(bus.BUSY),      32'd0);
      check("rst_err",       32'(bus.ERR),       32'd0);
      tick();
      RST = 1'b0;
      check("rel_req_ready_pre", 32'(bus.REQ_READY), 32'd0);
      tick();
      check("rel_req_ready_post", 32'(bus.REQ_READY), 32'd1);

      // T2 single read
      regs_m[3] = 16'hBEEF;
      apply_regs();
      bus.RD_READY = 1'b1;
      push_burst(3, 1);
      issue(3'd3, 4'd1);
      check("t2_valid", 32'(bus.RD_VALID), 32'd1);
      check("t2_data",  32'(bus.RD_DATA),  32'hBEEF);
      check("t2_addr",  32'(bus.RD_ADDR),  32'd3);
      check("t2_last",  32'(bus.RD_LAST),  32'd1);
      check("t2_busy",  32'(bus.BUSY),     32'd1);
      check("t2_ready_busy", 32'(bus.REQ_READY), 32'd0);
      tick();
      check("t2_valid_end", 32'(bus.RD_VALID),  32'd0);
      check("t2_ready_end", 32'(bus.REQ_READY), 32'd1);
      check("t2_busy_end",  32'(bus.BUSY),      32'd0);
      check("t2_data_hold", 32'(bus.RD_DATA),   32'hBEEF);

      // T3 burst with wrap 6,7,0,1
      for (int i = 0; i < 8; i++) regs_m[i] = 16'h1000 + 16'(i);
      apply_regs();
      push_burst(6, 4);
      issue(3'd6, 4'd4);
      for (int k = 0; k < 4; k++) begin
         check("t3_valid", 32'(bus.RD_VALID), 32'd1);
         check("t3_last",  32'(bus.RD_LAST),  32'(k == 3));
         tick();
      end
      check("t3_valid_end", 32'(bus.RD_VALID), 32'd0);

      // T4 backpressure with REG_Q changing under the held beat
      bus.RD_READY = 1'b0;
      orig = regs_m[2];
      push_burst(2, 2);
      issue(3'd2, 4'd2);
      for (int k = 0; k < 3; k++) begin
         check("t4_hold_data", 32'(bus.RD_DATA), 32'(orig));
         check("t4_hold_addr", 32'(bus.RD_ADDR), 32'd2);
         regs_m[2] = 16'hA5A0 + 16'(k);
         apply_regs();
         tick();
      end
      check("t4_hold_final", 32'(bus.RD_DATA), 32'(orig));
      bus.RD_READY = 1'b1;
      tick();
      check("t4_b1_valid", 32'(bus.RD_VALID), 32'd1);
      check("t4_b1_addr",  32'(bus.RD_ADDR),  32'd3);
      check("t4_b1_last",  32'(bus.RD_LAST),  32'd1);
      tick();
      check("t4_idle", 32'(bus.RD_VALID), 32'd0);

      // T5 illegal lengths 0 and 9
      issue(3'd0, 4'd0);
      check("t5a_err",   32'(bus.ERR),       32'd1);
      check("t5a_ready", 32'(bus.REQ_READY), 32'd1);
      check("t5a_valid", 32'(bus.RD_VALID),  32'd0);
      tick();
      check("t5a_err_clr", 32'(bus.ERR),      32'd0);
      check("t5a_valid2",  32'(bus.RD_VALID), 32'd0);
      issue(3'd0, 4'd9);
      check("t5b_err",   32'(bus.ERR),       32'd1);
      check("t5b_ready", 32'(bus.REQ_READY), 32'd1);
      check("t5b_valid", 32'(bus.RD_VALID),  32'd0);
      tick();
      check("t5b_err_clr", 32'(bus.ERR),      32'd0);
      check("t5b_valid2",  32'(bus.RD_VALID), 32'd0);

      // T6 REQ_VALID held through a LEN=8 burst
      push_burst(0, 8);
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR  = 3'd0;
      bus.REQ_LEN   = 4'd8;
      tick();
      beats = 0;
      for (int n = 0; n < 30 && !bus.REQ_READY; n++) begin
         if (bus.RD_VALID) beats++;
         tick();
      end
      check("t6_beats", 32'(beats), 32'd8);
      check("t6_ready", 32'(bus.REQ_READY), 32'd1);
      bus.REQ_ADDR = 3'd5;
      bus.REQ_LEN  = 4'd1;
      push_burst(5, 1);
      tick();
      bus.REQ_VALID = 1'b0;
      check("t6_second_valid", 32'(bus.RD_VALID), 32'd1);
      check("t6_second_addr",  32'(bus.RD_ADDR),  32'd5);
      wait_idle();

      // T1 reset mid-burst
      bus.RD_READY = 1'b0;
      push_burst(1, 8);
      issue(3'd1, 4'd8);
      tick();
      RST = 1'b1;
      exp_q.delete();
      #1;
      check("t1_valid", 32'(bus.RD_VALID),  32'd0);
      check("t1_busy",  32'(bus.BUSY),      32'd0);
      check("t1_ready", 32'(bus.REQ_READY), 32'd0);
      tick();
      RST = 1'b0;
      bus.RD_READY = 1'b1;
      check("t1_ready_pre", 32'(bus.REQ_READY), 32'd0);
      tick();
      check("t1_ready_post", 32'(bus.REQ_READY), 32'd1);
      for (int k = 0; k < 3; k++) begin
         check("t1_no_residual", 32'(bus.RD_VALID), 32'd0);
         tick();
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
